iir_bandpass_seq: RTL and testbench
===================================

Name: iir_bandpass_seq

Overview:
- Digital, sampled-domain successor to the two-stage op-amp RC bandpass: a cascade of NUM_SEC parametrised first-order IIR sections.
- Each section is coefficient-programmed as high-pass or low-pass, covering the HP-then-LP bandpass plus higher orders.
- One time-shared multiplier, sequenced by an FSM, processes one sample at a time.
- Valid/ready streaming on input and output; sits between the sample source and downstream AC/measurement logic.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- COEF_W, 16: coefficient width, signed, with FRAC_W fraction bits.
- FRAC_W, 14: coefficient fractional bits (1.0 = 16384).
- NUM_SEC, 2: number of cascaded first-order sections, minimum 1.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input sample valid.
- in_ready, out, 1: block can accept a sample.
- in_data, in, DATA_W: input sample.
- out_valid, out, 1: output sample valid.
- out_ready, in, 1: downstream accepts the output sample.
- out_data, out, DATA_W: filtered sample.
- cfg_we, in, 1: coefficient write strobe.
- cfg_addr, in, clog2(3*NUM_SEC): coefficient index, 3*s+k. k=0 is a (x), k=1 is b (x_prev), k=2 is c (y_prev).
- cfg_data, in, COEF_W: coefficient value.
- cfg_err, out, 1: one-cycle pulse when a write is rejected.
- sat_flag, out, 1: sticky; set on any section saturation; cleared only by rst.
- busy, out, 1: FSM not in IDLE.

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, cfg_err=0, sat_flag=0, busy=0.
  - All x_prev/y_prev state = 0.
  - Coefficients: a=1.0 (1<<FRAC_W), b=0, c=0 (passthrough).
- Reset mid-operation: aborts the current sample and any pending output; the output is never delivered.
- Section equation: y = round(a*x + b*x_prev + c*y_prev).
  - Accumulator width DATA_W+COEF_W+2.
  - Rounding: add 1<<(FRAC_W-1), then arithmetic shift right FRAC_W.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; saturation sets sat_flag.
  - After a section: x_prev[s] <= x, y_prev[s] <= saturated y; y feeds section s+1 as x.
- FSM states:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready, latch in_data, s=0, k=0, go to MAC.
  - MAC: one product per cycle for k=0,1,2, accumulated. At k=2, commit section s. If s<NUM_SEC-1, s++ and k=0; else go to OUT.
  - OUT: out_valid=1, out_data held stable, in_ready=0. On out_ready, go to IDLE.
- Latency: out_valid rises on the 3*NUM_SEC+1-th rising edge after the acceptance edge (7 for default).
- Throughput: at most 1 sample per 3*NUM_SEC+2 cycles.
- Simultaneous events: in OUT with out_ready=1 and in_valid=1, the new sample is not accepted that cycle, because in_ready is low in OUT.
- Config writes:
  - Accepted only in IDLE and only when no sample is accepted the same cycle.
  - The write takes effect for the next accepted sample.
  - Rejected with a cfg_err pulse (coefficient unchanged) when: busy=1, or in the same cycle as an input acceptance, or cfg_addr >= 3*NUM_SEC.
- Section state (x_prev/y_prev) is not cleared by config writes.

Decomposition:
- Shared package iir_pkg:
  - Width constants: ACC_W = DATA_W+COEF_W+2.
  - FSM state enum {IDLE, MAC, OUT}.
  - Coefficient index enum {K_A, K_B, K_C}.
  - Functions round_shift() and sat_to_data().
- One sub-module iir_mac_unit: registered multiply-accumulate with clear, round and saturate, sat output.
- The FSM, coefficient register file and section state remain in the top module.

Test Plan:
- Reset passthrough: after rst, in_data=1000 accepted -> out_data=1000 with out_valid exactly 7 cycles later; sat_flag=0.
- Low-pass impulse response:
  - Setup: sec0 a=8192, b=0, c=8192; sec1 passthrough.
  - Stimulus: impulse 16384, then zeros.
  - Required outputs: 8192, 4096, 2048, 1024.
- High-pass step response:
  - Setup: sec0 a=8192, b=-8192, c=8192.
  - Stimulus: step of 16384s.
  - Required outputs: 8192, 4096, 2048, decaying to 0.
- Saturation: sec0 a=32767 (≈2.0); in_data=30000 -> out_data=32767, sat_flag=1 and remaining 1 after later normal samples.
- Backpressure: out_ready=0 for 5 cycles in OUT -> out_data/out_valid stable, in_ready=0; sample accepted only after the out_ready handshake.
- Config rejection and reset:
  - cfg_we while busy, or with cfg_addr=6 -> cfg_err one-cycle pulse, coefficient unchanged.
  - rst asserted during MAC -> no out_valid, in_ready=1 next cycle, state zeroed.

Source files
------------

// File: rtl/iir_pkg.sv
// -----------------------------------------------------------------------------
// iir_pkg
// Shared definitions for the time-shared first-order IIR cascade:
//   - default widths and the accumulator width rule
//   - FSM state and coefficient-index enums
//   - round_shift(): round-half-up followed by an arithmetic right shift
//   - sat_to_data(): clamp a wide value into the signed sample range
// The helpers work on 64-bit signed values so that they serve any
// parameterisation with an accumulator narrower than 64 bits.
// -----------------------------------------------------------------------------
package iir_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int COEF_W_DEF  = 16;
    localparam int FRAC_W_DEF  = 14;
    localparam int NUM_SEC_DEF = 2;

    // Three products of DATA_W x COEF_W bits summed need two guard bits.
    localparam int ACC_W = DATA_W_DEF + COEF_W_DEF + 2;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_e;

    // Which coefficient of a section is being applied:
    // a multiplies x, b multiplies x_prev, c multiplies y_prev.
    typedef enum logic [1:0] {
        K_A,
        K_B,
        K_C
    } kidx_e;

    function automatic logic signed [63:0] round_shift(
        input logic signed [63:0] acc,
        input int                 frac
    );
        logic signed [63:0] bias;
        bias = 64'sd1 <<< (frac - 1);
        return (acc + bias) >>> frac;
    endfunction

    function automatic logic signed [63:0] sat_to_data(
        input logic signed [63:0] v,
        input int                 dw
    );
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        maxv = (64'sd1 <<< (dw - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (dw - 1));
        if (v > maxv) begin
            return maxv;
        end else if (v < minv) begin
            return minv;
        end
        return v;
    endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// -----------------------------------------------------------------------------
// iir_mac_unit
// Registered multiply-accumulate used by every section of the cascade.
// Each enabled cycle adds data_i*coef_i to the accumulator; clr_i makes
// that product the first term of a fresh sum. y_o/sat_o present the
// rounded and saturated value of the registered accumulator, so a
// section's result is available the cycle after its last product.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   en_i       accumulate this cycle
//   clr_i      start a new sum with this cycle's product
//   data_i     signed sample operand
//   coef_i     signed coefficient operand (FRAC_W fraction bits)
//   y_o        rounded, saturated accumulator value
//   sat_o      y_o was clamped
// -----------------------------------------------------------------------------
module iir_mac_unit
    import iir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int ACC_W  = DATA_W + COEF_W + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [DATA_W-1:0] y_o,
    output logic                     sat_o
);

    localparam int PW = DATA_W + COEF_W;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [63:0]      acc_ext;
    logic signed [63:0]      rounded;

    // Product and next accumulator value; the product is sign-extended
    // explicitly so the sum is correct regardless of expression signing.
    always_comb begin
        prod     = data_i * coef_i;
        acc_base = clr_i ? '0 : acc_q;
        acc_d    = acc_base + {{(ACC_W - PW){prod[PW-1]}}, prod};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    // Result path: widen, round half-up, then clamp to the sample range.
    always_comb begin
        acc_ext = {{(64 - ACC_W){acc_q[ACC_W-1]}}, acc_q};
        rounded = round_shift(acc_ext, FRAC_W);
        y_o     = DATA_W'(sat_to_data(rounded, DATA_W));
        sat_o   = (sat_to_data(rounded, DATA_W) != rounded);
    end

endmodule

// File: rtl/iir_bandpass_seq.sv
// -----------------------------------------------------------------------------
// iir_bandpass_seq
// Cascade of NUM_SEC first-order IIR sections, y = a*x + b*x_prev + c*y_prev,
// sharing one multiplier. Programming a section as high-pass or low-pass
// is purely a matter of coefficients; HP followed by LP gives a bandpass.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    input handshake, in_data is the signed sample
//   out_valid/out_ready  output handshake, out_data held while stalled
//   cfg_we/addr/data     coefficient write, addr = 3*section + k
//   cfg_err              one-cycle pulse for a rejected write
//   sat_flag             sticky saturation indicator
//   busy                 a sample is in flight or waiting for delivery
//
// Timing: the sample is accepted on edge 0, sections run three MAC
// cycles each, and the last section is committed on one extra cycle
// once its sum sits in the accumulator register. out_valid therefore
// rises 3*NUM_SEC+1 edges after acceptance.
// -----------------------------------------------------------------------------
module iir_bandpass_seq
    import iir_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int COEF_W  = COEF_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int NUM_SEC = NUM_SEC_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    input  logic                            cfg_we,
    input  logic [$clog2(3*NUM_SEC)-1:0]    cfg_addr,
    input  logic [COEF_W-1:0]               cfg_data,
    output logic                            cfg_err,
    output logic                            sat_flag,
    output logic                            busy
);

    localparam int AW    = $clog2(3 * NUM_SEC);
    localparam int SW    = $clog2(NUM_SEC + 1);
    localparam int NCOEF = 1 << AW;
    localparam int NSLOT = 1 << SW;

    localparam logic [AW-1:0]          COEF_LIMIT = AW'(3 * NUM_SEC);
    localparam logic [SW-1:0]          LAST_STEP  = SW'(NUM_SEC);
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC_W);

    state_e state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    kidx_e k_q, k_d;

    logic signed [COEF_W-1:0] coef_q  [0:NCOEF-1];
    logic signed [DATA_W-1:0] xprev_q [0:NSLOT-1];
    logic signed [DATA_W-1:0] yprev_q [0:NSLOT-1];
    logic signed [DATA_W-1:0] secx_q;
    logic [DATA_W-1:0]        out_data_q;
    logic                     cfg_err_q;
    logic                     sat_q;

    logic                     accept;
    logic                     cfg_ok;
    logic                     drain;
    logic                     commit;
    logic                     mac_en;
    logic                     mac_clr;
    logic [AW-1:0]            coef_idx;
    logic signed [DATA_W-1:0] mac_x;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [DATA_W-1:0] mac_y;
    logic                     mac_sat;

    // State register for the sequencer (state, section, coefficient step).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= K_A;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
        end
    end

    // Next-state logic. The step with s == NUM_SEC issues no product; it
    // only commits the final section and hands the result to OUT.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MAC;
                    s_d     = '0;
                    k_d     = K_A;
                end
            end
            MAC: begin
                if (drain) begin
                    state_d = OUT;
                end else begin
                    case (k_q)
                        K_A:     k_d = K_B;
                        K_B:     k_d = K_C;
                        default: begin
                            k_d = K_A;
                            s_d = s_q + 1'b1;
                        end
                    endcase
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == OUT);
        busy      = (state_q != IDLE);
    end

    // Datapath control and operand selection. At k == a of section s > 0
    // the accumulator holds section s-1's complete sum, so its rounded
    // value is both the commit value and the x operand for section s.
    always_comb begin
        accept   = in_valid && in_ready;
        cfg_ok   = cfg_we && (state_q == IDLE) && !accept && (cfg_addr < COEF_LIMIT);
        drain    = (s_q == LAST_STEP);
        commit   = (state_q == MAC) && (k_q == K_A) && (s_q != '0);
        mac_en   = (state_q == MAC) && !drain;
        mac_clr  = (k_q == K_A);
        coef_idx = AW'(3 * int'(s_q) + int'(k_q));
        mac_coef = coef_q[coef_idx];
        case (k_q)
            K_A:     mac_x = (s_q == '0) ? secx_q : mac_y;
            K_B:     mac_x = xprev_q[s_q];
            default: mac_x = yprev_q[s_q];
        endcase
    end

    iir_mac_unit #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (DATA_W + COEF_W + 2)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .en_i   (mac_en),
        .clr_i  (mac_clr),
        .data_i (mac_x),
        .coef_i (mac_coef),
        .y_o    (mac_y),
        .sat_o  (mac_sat)
    );

    // Coefficient file, per-section history, output register and flags.
    // Reset restores passthrough coefficients and clears all history.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCOEF; i++) begin
                coef_q[i] <= (i % 3 == 0) ? COEF_ONE : '0;
            end
            for (int i = 0; i < NSLOT; i++) begin
                xprev_q[i] <= '0;
                yprev_q[i] <= '0;
            end
            secx_q     <= '0;
            out_data_q <= '0;
            cfg_err_q  <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            if (accept) begin
                secx_q <= in_data;
            end
            if (commit) begin
                xprev_q[s_q - 1'b1] <= secx_q;
                yprev_q[s_q - 1'b1] <= mac_y;
                secx_q              <= mac_y;
                if (mac_sat) begin
                    sat_q <= 1'b1;
                end
                if (drain) begin
                    out_data_q <= mac_y;
                end
            end
            cfg_err_q <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                coef_q[cfg_addr] <= cfg_data;
            end
        end
    end

    assign out_data = out_data_q;
    assign cfg_err  = cfg_err_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_iir_bandpass_seq.sv
// -----------------------------------------------------------------------------
// tb_iir_bandpass_seq
// Directed bench for the IIR cascade. A sample-level model computes each
// expected output when the sample is accepted; a monitor compares every
// delivered output against it, and directed checks pin literal values.
// -----------------------------------------------------------------------------
module tb_iir_bandpass_seq;

    localparam int DATA_W  = 16;
    localparam int COEF_W  = 16;
    localparam int FRAC_W  = 14;
    localparam int NUM_SEC = 2;
    localparam int NC      = 3 * NUM_SEC;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              cfg_we;
    logic [2:0]        cfg_addr;
    logic [COEF_W-1:0] cfg_data;
    logic              cfg_err;
    logic              sat_flag;
    logic              busy;

    int     checks = 0;
    int     passes = 0;
    longint expQ[$];
    longint lastOut;

    longint mCoef [NC];
    longint mXp   [NUM_SEC];
    longint mYp   [NUM_SEC];
    bit     mSat;

    iir_bandpass_seq #(
        .DATA_W  (DATA_W),
        .COEF_W  (COEF_W),
        .FRAC_W  (FRAC_W),
        .NUM_SEC (NUM_SEC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .sat_flag  (sat_flag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < NC; i++) begin
            mCoef[i] = (i % 3 == 0) ? (64'sd1 <<< FRAC_W) : 0;
        end
        for (int s = 0; s < NUM_SEC; s++) begin
            mXp[s] = 0;
            mYp[s] = 0;
        end
        mSat = 1'b0;
    endfunction

    function automatic longint modelSample(input longint xin);
        longint x;
        longint acc;
        longint y;
        x = xin;
        for (int s = 0; s < NUM_SEC; s++) begin
            acc = mCoef[3*s] * x + mCoef[3*s+1] * mXp[s] + mCoef[3*s+2] * mYp[s];
            y = (acc + (64'sd1 <<< (FRAC_W - 1))) >>> FRAC_W;
            if (y > 32767) begin
                y = 32767;
                mSat = 1'b1;
            end else if (y < -32768) begin
                y = -32768;
                mSat = 1'b1;
            end
            mXp[s] = x;
            mYp[s] = y;
            x = y;
        end
        return x;
    endfunction

    // Output monitor: every delivered sample is matched against the model.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected out_valid", 1, 0);
            end else begin
                checkOutput("out_data vs model", longint'($signed(out_data)), expQ.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        modelReset();
        expQ.delete();
    endtask

    task automatic acceptSample(input longint x);
        int i;
        i = 0;
        while (!in_ready && i < 40) begin
            tick();
            i++;
        end
        if (!in_ready) checkOutput("in_ready timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = 16'(x);
        tick();
        in_valid = 1'b0;
        expQ.push_back(modelSample(x));
    endtask

    task automatic waitOutput(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) checkOutput("out_valid timeout", 0, 1);
        lastOut = longint'($signed(out_data));
    endtask

    task automatic applyStimulus(input longint x, output longint y);
        int n;
        acceptSample(x);
        waitOutput(n);
        checkOutput("latency", n, 3 * NUM_SEC + 1);
        y = lastOut;
        tick();
    endtask

    task automatic cfgWrite(input int addr, input longint data, input bit expErr);
        cfg_we   = 1'b1;
        cfg_addr = 3'(addr);
        cfg_data = 16'(data);
        tick();
        cfg_we = 1'b0;
        checkOutput("cfg_err", cfg_err, expErr);
        if (!expErr) mCoef[addr] = data;
        tick();
        checkOutput("cfg_err pulse end", cfg_err, 0);
    endtask

    initial begin
        longint y;
        int     n;
        bit     sawValid;
        longint held;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        resetDut();

        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_data", out_data, 0);
        checkOutput("reset cfg_err", cfg_err, 0);
        checkOutput("reset sat_flag", sat_flag, 0);
        checkOutput("reset busy", busy, 0);

        $display("[TB] passthrough");
        applyStimulus(1000, y);
        checkOutput("passthrough 1000", y, 1000);
        checkOutput("passthrough sat_flag", sat_flag, 0);

        $display("[TB] low-pass impulse");
        resetDut();
        cfgWrite(0, 8192, 0);
        cfgWrite(1, 0, 0);
        cfgWrite(2, 8192, 0);
        applyStimulus(16384, y); checkOutput("lp[0]", y, 8192);
        applyStimulus(0, y);     checkOutput("lp[1]", y, 4096);
        applyStimulus(0, y);     checkOutput("lp[2]", y, 2048);
        applyStimulus(0, y);     checkOutput("lp[3]", y, 1024);

        $display("[TB] high-pass step");
        resetDut();
        cfgWrite(0, 8192, 0);
        cfgWrite(1, -8192, 0);
        cfgWrite(2, 8192, 0);
        applyStimulus(16384, y); checkOutput("hp[0]", y, 8192);
        applyStimulus(16384, y); checkOutput("hp[1]", y, 4096);
        applyStimulus(16384, y); checkOutput("hp[2]", y, 2048);
        for (int i = 0; i < 8; i++) applyStimulus(16384, y);
        checkOutput("hp[10]", y, 8);

        $display("[TB] saturation");
        resetDut();
        cfgWrite(0, 32767, 0);
        applyStimulus(30000, y);
        checkOutput("sat out", y, 32767);
        checkOutput("sat_flag set", sat_flag, 1);
        applyStimulus(100, y);
        checkOutput("post-sat out", y, 200);
        checkOutput("sat_flag sticky", sat_flag, 1);
        checkOutput("model sat agrees", sat_flag, longint'(mSat));

        $display("[TB] backpressure");
        resetDut();
        out_ready = 1'b0;
        acceptSample(5000);
        waitOutput(n);
        held = lastOut;
        checkOutput("bp latency", n, 7);
        in_valid = 1'b1;
        in_data  = 16'd777;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp out_valid", out_valid, 1);
            checkOutput("bp out_data", longint'($signed(out_data)), held);
            checkOutput("bp in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("bp idle after handshake", busy, 0);
        expQ.push_back(modelSample(777));
        tick();
        in_valid = 1'b0;
        checkOutput("bp next accepted", busy, 1);
        waitOutput(n);
        checkOutput("bp second out", lastOut, 777);
        tick();

        $display("[TB] config rejection");
        resetDut();
        acceptSample(1234);
        checkOutput("busy in MAC", busy, 1);
        checkOutput("in_ready in MAC", in_ready, 0);
        cfgWrite(0, 0, 1);
        waitOutput(n);
        checkOutput("out after busy write", lastOut, 1234);
        tick();
        applyStimulus(4321, y);
        checkOutput("coef kept after busy write", y, 4321);
        cfgWrite(6, 0, 1);
        applyStimulus(555, y);
        checkOutput("coef kept after bad addr", y, 555);
        in_valid = 1'b1; in_data = 16'd2222;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'd0;
        tick();
        in_valid = 1'b0; cfg_we = 1'b0;
        expQ.push_back(modelSample(2222));
        checkOutput("cfg_err with accept", cfg_err, 1);
        waitOutput(n);
        checkOutput("out with accept-write", lastOut, 2222);
        tick();
        applyStimulus(3333, y);
        checkOutput("coef kept after accept-write", y, 3333);

        $display("[TB] reset during MAC");
        cfgWrite(0, 8192, 0);
        cfgWrite(2, 8192, 0);
        applyStimulus(16384, y);
        in_valid = 1'b1; in_data = 16'd9999;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
        expQ.delete();
        checkOutput("rst in_ready", in_ready, 1);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst out_valid", out_valid, 0);
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("no out_valid after rst", sawValid, 0);
        cfgWrite(0, 8192, 0);
        cfgWrite(2, 8192, 0);
        applyStimulus(0, y);
        checkOutput("history cleared", y, 0);
        applyStimulus(16384, y);
        checkOutput("fresh lp after rst", y, 8192);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
